// File: rtl/mem_stage.sv
// Memory-access stage: word loads/stores against a private data memory
// with a multi-cycle load FSM, producing the MEM_WB pipeline register.
module mem_stage #(
  parameter int ADDR_W       = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EX_MEM_MemReadOut,
  input  logic        EX_MEM_MemWriteOut,
  input  logic        EX_MEM_MemtoRegOut,
  input  logic        EX_MEM_RegWrite,
  input  logic [31:0] EX_MEM_ALUResult,
  input  logic [31:0] EX_MEM_WriteData,
  input  logic [4:0]  EX_MEM_WriteReg,
  output logic        MemStall,
  output logic        MemFault,
  output logic        MEM_WB_RegWrite,
  output logic        MEM_WB_MemtoReg,
  output logic [31:0] MEM_WB_ReadData,
  output logic [31:0] MEM_WB_ALUResult,
  output logic [4:0]  MEM_WB_WriteReg
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam bit MULTI = (READ_LATENCY > 1);
  localparam logic [2:0] CNT_INIT =
    MULTI ? 3'(READ_LATENCY - 2) : 3'd0;

  logic [0:0]  r_state;
  logic [2:0]  r_cnt;
  logic [31:0] r_mem [DEPTH];

  logic              w_aligned;
  logic              w_memop;
  logic              w_mis;
  logic              w_both;
  logic              w_load;
  logic              w_store;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_rdata;
  logic              w_unused;

  assign w_aligned = (EX_MEM_ALUResult[1:0] == 2'b00);
  assign w_memop   = EX_MEM_MemReadOut | EX_MEM_MemWriteOut;
  assign w_mis     = w_memop & ~w_aligned;
  assign w_both    = EX_MEM_MemReadOut & EX_MEM_MemWriteOut;
  assign w_load    = EX_MEM_MemReadOut & ~EX_MEM_MemWriteOut
                   & w_aligned;
  assign w_store   = EX_MEM_MemWriteOut & w_aligned;
  assign w_idx     = EX_MEM_ALUResult[ADDR_W+1:2];
  assign w_rdata   = r_mem[w_idx];
  assign w_unused  = ^EX_MEM_ALUResult[31:ADDR_W+2];

  assign MemStall = ~rst & ((r_state == S_IDLE)
                    ? (w_load & MULTI)
                    : (r_cnt != 3'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (r_state == S_IDLE && w_store) begin
      r_mem[w_idx] <= EX_MEM_WriteData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      MemFault         <= 1'b0;
      MEM_WB_RegWrite  <= 1'b0;
      MEM_WB_MemtoReg  <= 1'b0;
      MEM_WB_ReadData  <= '0;
      MEM_WB_ALUResult <= '0;
      MEM_WB_WriteReg  <= '0;
    end else if (r_state == S_IDLE) begin
      MemFault <= w_mis | w_both;
      if (w_load && MULTI) begin
        r_state          <= S_WAIT;
        r_cnt            <= CNT_INIT;
        MEM_WB_RegWrite  <= 1'b0;
        MEM_WB_MemtoReg  <= 1'b0;
        MEM_WB_ReadData  <= '0;
        MEM_WB_ALUResult <= '0;
        MEM_WB_WriteReg  <= '0;
      end else begin
        MEM_WB_RegWrite  <= EX_MEM_RegWrite & ~w_mis;
        MEM_WB_MemtoReg  <= EX_MEM_MemtoRegOut & ~w_both;
        MEM_WB_ReadData  <= w_load ? w_rdata : 32'd0;
        MEM_WB_ALUResult <= EX_MEM_ALUResult;
        MEM_WB_WriteReg  <= EX_MEM_WriteReg;
      end
    end else begin
      MemFault <= 1'b0;
      if (r_cnt != 3'd0) begin
        r_cnt            <= r_cnt - 3'd1;
        MEM_WB_RegWrite  <= 1'b0;
        MEM_WB_MemtoReg  <= 1'b0;
        MEM_WB_ReadData  <= '0;
        MEM_WB_ALUResult <= '0;
        MEM_WB_WriteReg  <= '0;
      end else begin
        // held inputs are the load's; capture completes it
        r_state          <= S_IDLE;
        MEM_WB_RegWrite  <= EX_MEM_RegWrite;
        MEM_WB_MemtoReg  <= EX_MEM_MemtoRegOut;
        MEM_WB_ReadData  <= w_rdata;
        MEM_WB_ALUResult <= EX_MEM_ALUResult;
        MEM_WB_WriteReg  <= EX_MEM_WriteReg;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: two instances, READ_LATENCY 2 and 4,
// sharing the EX_MEM inputs.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr, mtr, rw;
  logic [31:0] alu, wd;
  logic [4:0]  wreg;

  logic        st2, ft2, rw2, mtr2;
  logic [31:0] rdat2, alu2;
  logic [4:0]  wreg2;
  logic        st4, ft4, rw4, mtr4;
  logic [31:0] rdat4, alu4;
  logic [4:0]  wreg4;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(8), .READ_LATENCY(2)) u_d2 (
    .clk(clk), .rst(rst),
    .EX_MEM_MemReadOut(rd), .EX_MEM_MemWriteOut(wr),
    .EX_MEM_MemtoRegOut(mtr), .EX_MEM_RegWrite(rw),
    .EX_MEM_ALUResult(alu), .EX_MEM_WriteData(wd),
    .EX_MEM_WriteReg(wreg),
    .MemStall(st2), .MemFault(ft2),
    .MEM_WB_RegWrite(rw2), .MEM_WB_MemtoReg(mtr2),
    .MEM_WB_ReadData(rdat2), .MEM_WB_ALUResult(alu2),
    .MEM_WB_WriteReg(wreg2)
  );

  mem_stage #(.ADDR_W(8), .READ_LATENCY(4)) u_d4 (
    .clk(clk), .rst(rst),
    .EX_MEM_MemReadOut(rd), .EX_MEM_MemWriteOut(wr),
    .EX_MEM_MemtoRegOut(mtr), .EX_MEM_RegWrite(rw),
    .EX_MEM_ALUResult(alu), .EX_MEM_WriteData(wd),
    .EX_MEM_WriteReg(wreg),
    .MemStall(st4), .MemFault(ft4),
    .MEM_WB_RegWrite(rw4), .MEM_WB_MemtoReg(mtr4),
    .MEM_WB_ReadData(rdat4), .MEM_WB_ALUResult(alu4),
    .MEM_WB_WriteReg(wreg4)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic m,
                       input logic g, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] dst);
    rd = r; wr = w; mtr = m; rw = g;
    alu = a; wd = d; wreg = dst;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic ld2(input logic [31:0] a, input logic [4:0] dst,
                     input logic [31:0] e);
    drive(1, 0, 1, 1, a, 32'd0, dst);
    #1;
    chk("ld_stall_hi", 32'(st2), 32'd1);
    tick();
    chk("ld_stall_lo", 32'(st2), 32'd0);
    chk("ld_bub_rw", 32'(rw2), 32'd0);
    chk("ld_bub_data", rdat2, 32'd0);
    chk("ld_bub_wreg", 32'(wreg2), 32'd0);
    tick();
    chk("ld_data", rdat2, e);
    chk("ld_wreg", 32'(wreg2), 32'(dst));
    chk("ld_rw", 32'(rw2), 32'd1);
    chk("ld_mtr", 32'(mtr2), 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    nop();
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom, $urandom, 5'($urandom));
      tick();
      chk("rst_rw", 32'(rw2), 32'd0);
      chk("rst_mtr", 32'(mtr2), 32'd0);
      chk("rst_data", rdat2, 32'd0);
      chk("rst_alu", alu2, 32'd0);
      chk("rst_wreg", 32'(wreg2), 32'd0);
      chk("rst_fault", 32'(ft2), 32'd0);
      chk("rst_stall", 32'(st2), 32'd0);
      chk("rst_data4", rdat4, 32'd0);
      chk("rst_stall4", 32'(st4), 32'd0);
    end
    nop();
    rst = 1'b0;
    #1;
    chk("post_rst_stall", 32'(st2), 32'd0);
    ld2(32'h10, 5'd3, 32'd0);

    drive(0, 1, 0, 0, 32'h0C, 32'hDEADBEEF, 5'd0);
    #1;
    chk("st_stall", 32'(st2), 32'd0);
    tick();
    chk("st_fault", 32'(ft2), 32'd0);
    ld2(32'h0C, 5'd5, 32'hDEADBEEF);

    drive(0, 0, 0, 1, 32'h123, 32'd0, 5'd7);
    #1;
    chk("alu_stall", 32'(st2), 32'd0);
    tick();
    chk("alu_res", alu2, 32'h123);
    chk("alu_wreg", 32'(wreg2), 32'd7);
    chk("alu_rw", 32'(rw2), 32'd1);
    chk("alu_data", rdat2, 32'd0);

    drive(1, 0, 1, 1, 32'h0D, 32'd0, 5'd9);
    #1;
    chk("mis_stall", 32'(st2), 32'd0);
    tick();
    chk("mis_fault", 32'(ft2), 32'd1);
    chk("mis_rw", 32'(rw2), 32'd0);
    nop();
    tick();
    chk("mis_fault_pulse", 32'(ft2), 32'd0);
    ld2(32'h0C, 5'd5, 32'hDEADBEEF);

    drive(1, 1, 1, 1, 32'h20, 32'h1234, 5'd4);
    #1;
    chk("both_stall", 32'(st2), 32'd0);
    tick();
    chk("both_fault", 32'(ft2), 32'd1);
    chk("both_mtr", 32'(mtr2), 32'd0);
    chk("both_rw", 32'(rw2), 32'd1);
    ld2(32'h20, 5'd6, 32'h1234);
    ld2(32'h0C, 5'd8, 32'hDEADBEEF);

    drive(1, 0, 1, 1, 32'h0C, 32'd0, 5'd5);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nop();
    #1;
    chk("rmid_stall", 32'(st2), 32'd0);
    chk("rmid_rw", 32'(rw2), 32'd0);
    chk("rmid_data", rdat2, 32'd0);
    chk("rmid_wreg", 32'(wreg2), 32'd0);
    ld2(32'h0C, 5'd5, 32'd0);

    nop();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 1, 0, 0, 32'h400, 32'h55, 5'd0);
    tick();
    drive(1, 0, 1, 1, 32'h000, 32'd0, 5'd11);
    #1;
    n = 0;
    while (st4 && n < 10) begin
      n++;
      tick();
      if (st4) chk("wrap_bubble", rdat4, 32'd0);
    end
    chk("wrap_stall_cycles", 32'(n), 32'd3);
    tick();
    chk("wrap_data", rdat4, 32'h55);
    chk("wrap_wreg", 32'(wreg4), 32'd11);
    chk("wrap_rw", 32'(rw4), 32'd1);
    nop();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, directly downstream of `EX_STAGE`. It consumes the `EX_MEM_*` pipeline register, performs word loads and stores against a private data memory with a configurable multi-cycle read latency, and produces the `MEM_WB_*` pipeline register for write-back. It stalls upstream stages during loads and flags misaligned or contradictory accesses.

## Interface
- `ADDR_W`, default 8: word-address width; the data memory holds 2^ADDR_W 32-bit words.
- `READ_LATENCY`, default 2: cycles per load, from first presentation to MEM_WB capture; legal range 1..8.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `EX_MEM_MemReadOut` in 1: load request.
- `EX_MEM_MemWriteOut` in 1: store request.
- `EX_MEM_MemtoRegOut` in 1: write-back selects memory data.
- `EX_MEM_RegWrite` in 1: instruction writes the register file.
- `EX_MEM_ALUResult` in 32: byte address for memory ops, or the result for ALU ops.
- `EX_MEM_WriteData` in 32: store data.
- `EX_MEM_WriteReg` in 5: destination register.
- `MemStall` out 1: combinational; upstream holds all `EX_MEM_*` inputs and IF/ID/EX registers while high.
- `MemFault` out 1: registered one-cycle pulse on a misaligned or contradictory access.
- `MEM_WB_RegWrite` out 1, `MEM_WB_MemtoReg` out 1: registered controls.
- `MEM_WB_ReadData` out 32, `MEM_WB_ALUResult` out 32, `MEM_WB_WriteReg` out 5: registered data.

## Operation
- Word index: `EX_MEM_ALUResult[ADDR_W+1:2]`. Upper address bits are ignored, so addresses wrap modulo memory size.
- Misaligned: a memory op with `EX_MEM_ALUResult[1:0]` != 0.
  - No memory read or write occurs.
  - MemFault pulses.
  - `MEM_WB_RegWrite` = 0 for that instruction.
  - No stall.
- MemRead and MemWrite both high:
  - The store is performed (if aligned) and the read is ignored.
  - MemFault pulses.
  - `MEM_WB_MemtoReg` = 0.
- Non-memory op:
  - MEM_WB captures RegWrite, MemtoReg, ALUResult and WriteReg.
  - `MEM_WB_ReadData` = 0.
- Store:
  - The memory word is written on the capture edge.
  - MEM_WB captures the controls as for a non-memory op (RegWrite as supplied).
  - Always single-cycle.
- Load, FSM states IDLE and WAIT with a 3-bit counter `cnt`:
  - IDLE, aligned load, READ_LATENCY > 1: MemStall = 1. At the next edge go to WAIT with `cnt` = READ_LATENCY−2, and MEM_WB loads a bubble (all outputs 0).
  - WAIT: MemStall = (`cnt` != 0). At an edge with `cnt` != 0: decrement `cnt` and keep the bubble. At an edge with `cnt` == 0: capture the memory word into `MEM_WB_ReadData` along with the controls, and go to IDLE.
  - READ_LATENCY = 1: the load completes in IDLE like a non-memory op, with no stall.
- Read data reflects all stores whose capture edge preceded the load's capture edge.

## Timing
- Reset (`rst` = 1 at an edge):
  - All MEM_WB outputs = 0, MemFault = 0, FSM = IDLE, `cnt` = 0.
  - All memory words = 0.
  - MemStall = 0 in the following cycle.
- Reset asserted mid-WAIT aborts the load: no capture, IDLE next cycle.
- Latency:
  - Non-memory op, store, or fault: 1 edge.
  - Aligned load: READ_LATENCY edges.
  - MemStall high for exactly READ_LATENCY−1 cycles per load.
- Back-to-back loads: the second load enters IDLE on the cycle after the first completes. There is no extra idle cycle.
- Inputs are sampled only in IDLE, or at the completing WAIT edge. Input changes during stall-high cycles are a protocol violation; the block uses the values held at first presentation.
- MemFault is registered: it is high during the cycle after the offending instruction's capture edge.

## Test plan
- Reset: hold `rst` for 2 cycles with random inputs → all outputs 0 and MemStall = 0; after release, a load from address 0x10 returns 0.
- Store then load, READ_LATENCY = 2:
  - Store 0xDEADBEEF to 0x0C, then load 0x0C with WriteReg = 5.
  - MemStall is high for 1 cycle and MEM_WB shows a bubble.
  - Then `MEM_WB_ReadData` = 0xDEADBEEF, WriteReg = 5, RegWrite = 1, MemtoReg = 1.
- ALU passthrough: ALUResult = 0x00000123, RegWrite = 1, WriteReg = 7, no memory op → next edge shows MEM_WB_ALUResult = 0x123 and WriteReg = 7, with no stall.
- Misaligned: load from 0x0D → MemFault = 1 for one cycle, MEM_WB_RegWrite = 0, no stall; a later load from 0x0C still returns the earlier value.
- Wrap and latency, ADDR_W = 8, READ_LATENCY = 4:
  - Store 0x55 to 0x400, then load 0x000.
  - The load returns 0x55.
  - MemStall is high for 3 consecutive cycles.
- Reset mid-load: assert `rst` during WAIT → no capture, outputs 0, MemStall = 0 the next cycle, memory cleared.
